// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and default parameters for the 5-bit UART loopback block.
//   uart_state_t is the common state encoding of the TX and RX sequencers.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Payload bits per frame
    localparam int UART_DATA_W       = 5;
    // Clock cycles per serial bit (even, >= 2)
    localparam int UART_CLKS_PER_BIT = 2;

endpackage : uart_pkg

// File: rtl/uart_chk.sv
// -----------------------------------------------------------------------------
// uart_chk
//   Protocol checks for the loopback block (simulation only).
// Ports
//   clk, rst   clock and synchronous reset of the checked block
//   busy       transmitter frame-in-flight flag
//   serial_q   internal serial line
// -----------------------------------------------------------------------------
module uart_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic serial_q
);

    // The line must rest high whenever no frame is in flight
    a_idle_high: assert property (@(posedge clk) disable iff (rst) (!busy |-> serial_q));

endmodule : uart_chk

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Recovers DATA_W-bit frames from the serial line by mid-bit sampling.
//   A start bit that is high again at mid-bit is treated as a glitch. A low
//   stop bit is a framing error: the word is dropped and the receiver waits
//   for the line to go high before re-arming.
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   rx     in   serial line
//   data   out  last good word (registered)
//   valid  out  one-cycle pulse when data has just been updated
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    uart_state_t       state_r;
    uart_state_t       state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              ferr_r;
    logic              start_mid_s;
    logic              sample_s;
    logic              good_stop_s;
    logic              set_ferr_s;

    assign start_mid_s = (cnt_r == HALF_LAST);
    assign sample_s    = (cnt_r == CNT_LAST);

    // State, saturating bit timer, sample shift register and output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= good_stop_s;

            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if (state_r == DATA && sample_s) begin
                cnt_r <= '0;
            end else if (state_r != IDLE && cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (state_r != DATA) begin
                idx_r <= '0;
            end else if (sample_s && (idx_r != IDX_LAST)) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end

            // Samples enter at the MSB so the first (LSB) bit lands in bit 0
            if (state_r == DATA && sample_s) begin
                shift_r <= {rx, shift_r[DATA_W-1:1]};
            end else begin
                shift_r <= shift_r;
            end

            if (good_stop_s) begin
                data_r <= shift_r;
            end else begin
                data_r <= data_r;
            end

            if (set_ferr_s) begin
                ferr_r <= 1'b1;
            end else if (state_nxt_s == IDLE) begin
                ferr_r <= 1'b0;
            end else begin
                ferr_r <= ferr_r;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx) state_nxt_s = START;
                else     state_nxt_s = IDLE;
            end
            START: begin
                if (start_mid_s) state_nxt_s = rx ? IDLE : DATA;
                else             state_nxt_s = START;
            end
            DATA: begin
                if (sample_s && (idx_r == IDX_LAST)) state_nxt_s = STOP;
                else                                 state_nxt_s = DATA;
            end
            STOP: begin
                // After a framing error only a high line re-arms the receiver
                if (ferr_r)        state_nxt_s = rx ? IDLE : STOP;
                else if (sample_s) state_nxt_s = rx ? IDLE : STOP;
                else               state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Stop-bit outcome strobes
    always_comb begin
        good_stop_s = 1'b0;
        set_ferr_s  = 1'b0;
        if (state_r == STOP && !ferr_r && sample_s) begin
            good_stop_s = rx;
            set_ferr_s  = !rx;
        end else begin
            good_stop_s = 1'b0;
            set_ferr_s  = 1'b0;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;

endmodule : uart_rx

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Serialises one DATA_W-bit word per frame: start 0, data LSB first, stop 1.
//   Each bit is held for CLKS_PER_BIT cycles. The line output is registered.
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   enable   in   transmit request, honoured in IDLE or on the last STOP cycle
//   data_in  in   word latched on the accepting edge
//   tx       out  serial line (idle high)
//   busy     out  high while a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state_t       state_r;
    uart_state_t       state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] shift_r;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              accept_s;
    logic              bit_end_s;
    logic              last_bit_s;

    assign bit_end_s  = (cnt_r == CNT_LAST);
    assign last_bit_s = (idx_r == IDX_LAST);

    // State, counters, shift register and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            tx_r    <= tx_nxt_s;

            // Bit timer restarts at every bit boundary and stays cleared in IDLE
            if (state_r == IDLE || bit_end_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (state_r != DATA) begin
                idx_r <= '0;
            end else if (bit_end_s) begin
                idx_r <= last_bit_s ? '0 : (idx_r + IDX_W'(1));
            end else begin
                idx_r <= idx_r;
            end

            if (accept_s) begin
                shift_r <= data_in;
            end else if (state_r == DATA && bit_end_s) begin
                shift_r <= shift_r >> 1;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Next-state decode; enable outside IDLE/last STOP cycle is dropped
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (bit_end_s) state_nxt_s = DATA;
                else           state_nxt_s = START;
            end
            DATA: begin
                if (bit_end_s && last_bit_s) state_nxt_s = STOP;
                else                         state_nxt_s = DATA;
            end
            STOP: begin
                if (bit_end_s) state_nxt_s = enable ? START : IDLE;
                else           state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Line value for the next cycle and the word-accept strobe
    always_comb begin
        accept_s = (state_nxt_s == START) && (state_r != START);
        tx_nxt_s = tx_r;
        case (state_nxt_s)
            IDLE:  tx_nxt_s = 1'b1;
            START: tx_nxt_s = 1'b0;
            DATA: begin
                // Entering DATA shows bit 0; each later boundary shows the bit
                // that is about to become shift_r[0].
                if (state_r == START) tx_nxt_s = shift_r[0];
                else if (bit_end_s)   tx_nxt_s = shift_r[1];
                else                  tx_nxt_s = tx_r;
            end
            STOP:    tx_nxt_s = 1'b1;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    assign tx   = tx_r;
    assign busy = (state_r != IDLE);

endmodule : uart_tx

// File: rtl/uart_top.sv
// -----------------------------------------------------------------------------
// uart_top
//   5-bit UART loopback: uart_tx drives serial_q, uart_rx listens to it, and
//   the last good word is presented on data_out.
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   data_in   in   word to send, sampled when enable is accepted
//   enable    in   transmit request, level-sampled each edge
//   data_out  out  last correctly received word; 0 after reset
// -----------------------------------------------------------------------------
module uart_top
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out
);

    logic              serial_q;
    logic              tx_busy_s;
    logic [DATA_W-1:0] rx_data_s;
    logic              rx_valid_s;

    uart_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .data_in(data_in),
        .tx     (serial_q),
        .busy   (tx_busy_s)
    );

    uart_rx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rx   (serial_q),
        .data (rx_data_s),
        .valid(rx_valid_s)
    );

    uart_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .busy    (tx_busy_s),
        .serial_q(serial_q)
    );

    // Output word only moves on a good stop bit or on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rx_valid_s) begin
            data_out <= rx_data_s;
        end else begin
            data_out <= data_out;
        end
    end

endmodule : uart_top

// File: tb/tb_uart_top.sv
// -----------------------------------------------------------------------------
// tb_uart_top
//   Directed self-checking bench for the 5-bit UART loopback block.
// -----------------------------------------------------------------------------
module tb_uart_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] data_in;
    logic [4:0] data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_top dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .enable  (enable),
        .data_out(data_out)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line value k cycles after the accepting edge (2 clks per bit)
    function automatic logic frame_bit(input logic [4:0] w, input int k);
        int pos;
        pos = k / 2;
        if (pos == 0)      return 1'b0;
        else if (pos <= 5) return w[pos-1];
        else               return 1'b1;
    endfunction

    // Send one word; optionally pulse enable with another word at cycle spur_at
    task automatic send_frame(input string tag, input logic [4:0] word,
                              input int spur_at, input logic [4:0] spur_word);
        data_in = word;
        enable  = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            enable  = (k == spur_at);
            data_in = (k == spur_at) ? spur_word : ~word;
            check_eq($sformatf("%s_line%0d", tag, k), 8'(dut.serial_q), 8'(frame_bit(word, k)));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("%s_idle%0d", tag, k), 8'(dut.serial_q), 8'h01);
        end
        check_eq($sformatf("%s_out", tag), 8'(data_out), 8'(word));
    endtask

    initial begin
        // 1. Reset
        rst     = 1'b1;
        enable  = 1'b0;
        data_in = 5'b00000;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_out", 8'(data_out), 8'h00);
        check_eq("rst_line", 8'(dut.serial_q), 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("post_rst_line%0d", k), 8'(dut.serial_q), 8'h01);
            check_eq($sformatf("post_rst_out%0d", k), 8'(data_out), 8'h00);
        end

        // 2. Single frame
        send_frame("w11001", 5'b11001, -1, 5'b00000);

        // 3. All zeros then all ones
        send_frame("w00000", 5'b00000, -1, 5'b00000);
        send_frame("w11111", 5'b11111, -1, 5'b00000);

        // 4. Enable during DATA is ignored
        send_frame("w10101", 5'b10101, 5, 5'b01010);

        // 5. Enable held for three frame times: back-to-back frames
        data_in = 5'b00111;
        enable  = 1'b1;
        for (int k = 0; k < 42; k++) begin
            tick();
            if (k == 41) enable = 1'b0;
            check_eq($sformatf("b2b_line%0d", k), 8'(dut.serial_q), 8'(frame_bit(5'b00111, k % 14)));
            if (k == 19) check_eq("b2b_out_first", 8'(data_out), 8'h07);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("b2b_idle%0d", k), 8'(dut.serial_q), 8'h01);
        end
        check_eq("b2b_out", 8'(data_out), 8'h07);

        // 6. Reset 6 cycles into a frame
        data_in = 5'b01101;
        enable  = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_out", 8'(data_out), 8'h00);
        check_eq("midrst_line", 8'(dut.serial_q), 8'h01);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_eq($sformatf("midrst_line%0d", k), 8'(dut.serial_q), 8'h01);
            check_eq($sformatf("midrst_out%0d", k), 8'(data_out), 8'h00);
        end
        send_frame("w10010", 5'b10010, -1, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_top
